// File: rtl/dds_pkg.sv
// dds_pkg: definitions shared by the DDS chain blocks (accumulator, button
// detector, sweep controller): phase-increment width and sweep state encoding.
package dds_pkg;

  localparam int PHINC_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/dds_dwell_cnt.sv
// dds_dwell_cnt: loadable down-counter that flags the last cycle of a dwell.
// The owner loads it with the (already non-zero) dwell length; expire_o is
// high while the count sits at 1, i.e. during the final cycle of the hold.
module dds_dwell_cnt
  import dds_pkg::*;
#(
  parameter int DWELL_W = 16
) (
  input  logic               clk_i,
  input  logic               clrn_ni,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] load_val_i,
  input  logic               en_i,
  output logic               expire_o
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  // Next count: a load wins over counting; counting stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge clk_i or negedge clrn_ni) begin
    if (!clrn_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == DWELL_W'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep sequencer feeding the DDS phase accumulator.
// Steps phinc from f_start to f_stop in f_step increments, holding each value
// for max(dwell,1) cycles, with a start/busy/done handshake and abort.
// Optional build macro DDS_SWEEP_LOOP_EN adds loop_i for a repeating sawtooth.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int W       = PHINC_W,
  parameter int DWELL_W = 16,
  parameter int DEFAULT = 1
) (
  input  logic               clk_i,
  input  logic               clrn_ni,
  input  logic               start_i,
  input  logic               abort_i,
`ifdef DDS_SWEEP_LOOP_EN
  input  logic               loop_i,
`endif
  input  logic [W-1:0]       f_start_i,
  input  logic [W-1:0]       f_stop_i,
  input  logic [W-1:0]       f_step_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [W-1:0]       phinc_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               dir_dn_o
);

  sweep_state_e       state_q;
  logic [W-1:0]       phinc_q;
  logic               busy_q;
  logic               done_q;
  logic               dir_dn_q;
  logic [W-1:0]       fstart_q;
  logic [W-1:0]       stop_q;
  logic [W-1:0]       step_q;
  logic [DWELL_W-1:0] dwell_q;

  logic [W-1:0]       phinc_d;
  logic [W:0]         sumUp;
  logic [W:0]         sumDn;
  logic               loopEn;
  logic               startFire;
  logic               atStop;
  logic               cntExpire;
  logic               cntLoad;
  logic [DWELL_W-1:0] cntLoadVal;

  function automatic logic [DWELL_W-1:0] dwellEff(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

  function automatic logic [W-1:0] stepEff(input logic [W-1:0] s);
    return (s == '0) ? W'(1) : s;
  endfunction

`ifdef DDS_SWEEP_LOOP_EN
  assign loopEn = loop_i;
`else
  assign loopEn = 1'b0;
`endif

  assign startFire = (state_q == ST_IDLE) && start_i && !abort_i;
  assign atStop    = (phinc_q == stop_q);

  // Counter reloads on sweep start and on every advance (including the loop
  // wrap), never on abort, so each value gets a full dwell.
  always_comb begin
    cntLoad    = startFire ||
                 ((state_q == ST_RUN) && !abort_i && cntExpire && (!atStop || loopEn));
    cntLoadVal = startFire ? dwellEff(dwell_i) : dwell_q;
  end

  dds_dwell_cnt #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk_i      (clk_i),
    .clrn_ni    (clrn_ni),
    .load_i     (cntLoad),
    .load_val_i (cntLoadVal),
    .en_i       (state_q == ST_RUN),
    .expire_o   (cntExpire)
  );

  // Next ramp value at W+1 bits; any overshoot (or underflow) clamps to f_stop.
  always_comb begin
    sumUp   = {1'b0, phinc_q} + {1'b0, step_q};
    sumDn   = {1'b0, phinc_q} - {1'b0, step_q};
    phinc_d = stop_q;
    if (!dir_dn_q) begin
      if (sumUp < {1'b0, stop_q}) begin
        phinc_d = sumUp[W-1:0];
      end
    end else begin
      if (!sumDn[W] && (sumDn > {1'b0, stop_q})) begin
        phinc_d = sumDn[W-1:0];
      end
    end
  end

  // Sweep FSM with registered phinc/busy/done/dir outputs.
  always_ff @(posedge clk_i or negedge clrn_ni) begin
    if (!clrn_ni) begin
      state_q  <= ST_IDLE;
      phinc_q  <= W'(DEFAULT);
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dir_dn_q <= 1'b0;
      fstart_q <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (startFire) begin
            fstart_q <= f_start_i;
            stop_q   <= f_stop_i;
            step_q   <= stepEff(f_step_i);
            dwell_q  <= dwellEff(dwell_i);
            phinc_q  <= f_start_i;
            busy_q   <= 1'b1;
            dir_dn_q <= (f_stop_i < f_start_i);
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort_i) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (cntExpire) begin
            if (atStop) begin
              if (loopEn) begin
                phinc_q <= fstart_q;
              end else begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= ST_FIN;
              end
            end else begin
              phinc_q <= phinc_d;
            end
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign phinc_o  = phinc_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign dir_dn_o = dir_dn_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: scoreboard bench for dds_sweep_ctrl. Each sweep issued
// pushes its expected per-cycle trace; a monitor pops one entry for every
// cycle in which the DUT shows busy or done.
module tb_dds_sweep_ctrl;

  typedef struct packed {
    logic [7:0] phinc;
    logic       busy;
    logic       done;
    logic       dir;
  } exp_t;

  logic        clk = 1'b0;
  logic        clrn;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        loop = 1'b0;
  logic [7:0]  fStart = '0;
  logic [7:0]  fStop = '0;
  logic [7:0]  fStep = '0;
  logic [15:0] dwell = '0;
  logic [7:0]  phinc;
  logic        busy;
  logic        done;
  logic        dirDn;

  int   compared = 0;
  int   mismatched = 0;
  exp_t sbq[$];

  dds_sweep_ctrl #(
    .W       (8),
    .DWELL_W (16),
    .DEFAULT (1)
  ) dut (
    .clk_i     (clk),
    .clrn_ni   (clrn),
    .start_i   (start),
    .abort_i   (abort),
`ifdef DDS_SWEEP_LOOP_EN
    .loop_i    (loop),
`endif
    .f_start_i (fStart),
    .f_stop_i  (fStop),
    .f_step_i  (fStep),
    .dwell_i   (dwell),
    .phinc_o   (phinc),
    .busy_o    (busy),
    .done_o    (done),
    .dir_dn_o  (dirDn)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Monitor: every busy/done cycle must match the next scoreboard entry.
  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    if (clrn && (busy || done)) begin
      act = {phinc, busy, done, dirDn};
      compared++;
      if (sbq.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_output: got phinc=%0d busy=%0b done=%0b dir=%0b, expected nothing",
                 phinc, busy, done, dirDn);
      end else begin
        e = sbq.pop_front();
        if (act !== e) begin
          mismatched++;
          $display("[TB] FAIL sweep_trace @%0t: got phinc=%0d busy=%0b done=%0b dir=%0b, expected phinc=%0d busy=%0b done=%0b dir=%0b",
                   $time, phinc, busy, done, dirDn, e.phinc, e.busy, e.done, e.dir);
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] timeout");
  end

  // Reference ramp: list of values from the spec rules using plain integers.
  function automatic void rampValues(input int fs, input int fe, input int st, output int vals[$]);
    int v;
    int s;
    s = (st == 0) ? 1 : st;
    v = fs;
    vals = {};
    vals.push_back(v);
    while (v != fe) begin
      if (fe < fs) v = (v - s < fe) ? fe : v - s;
      else         v = (v + s > fe) ? fe : v + s;
      vals.push_back(v);
    end
  endfunction

  function automatic int sweepLen(input int fs, input int fe, input int st, input int dw);
    int vals[$];
    rampValues(fs, fe, st, vals);
    return vals.size() * ((dw == 0) ? 1 : dw);
  endfunction

  // Push expected busy cycles (keep>0: only the first keep cycles, wrapping
  // the ramp for loop mode; keep==0: whole sweep plus the done cycle).
  // holdVal returns the phinc expected once the sweep has stopped.
  function automatic void pushSweep(input int fs, input int fe, input int st, input int dw,
                                    input int keep, output int holdVal);
    int   vals[$];
    int   d;
    int   n;
    int   cycles;
    exp_t e;
    rampValues(fs, fe, st, vals);
    d      = (dw == 0) ? 1 : dw;
    n      = vals.size() * d;
    cycles = (keep > 0) ? keep : n;
    for (int c = 1; c <= cycles; c++) begin
      e.phinc = 8'(vals[((c - 1) / d) % vals.size()]);
      e.busy  = 1'b1;
      e.done  = 1'b0;
      e.dir   = (fe < fs);
      sbq.push_back(e);
      holdVal = vals[((c - 1) / d) % vals.size()];
    end
    if (keep == 0) begin
      e.phinc = 8'(fe);
      e.busy  = 1'b0;
      e.done  = 1'b1;
      e.dir   = (fe < fs);
      sbq.push_back(e);
      holdVal = fe;
    end
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int expPh, input logic expBusy,
                             input logic expDone, input logic expDir);
    compared++;
    if ((phinc !== 8'(expPh)) || (busy !== expBusy) || (done !== expDone) || (dirDn !== expDir)) begin
      mismatched++;
      $display("[TB] FAIL %s: got phinc=%0d busy=%0b done=%0b dir=%0b, expected phinc=%0d busy=%0b done=%0b dir=%0b",
               name, phinc, busy, done, dirDn, expPh, expBusy, expDone, expDir);
    end
  endtask

  // One sweep: start pulse, random junk on data inputs and start while running,
  // optional abort during busy cycle abortAt, then idle/hold checks.
  task automatic applyStimulus(input string name, input int fs, input int fe, input int st,
                               input int dw, input int abortAt, input logic lp);
    int n;
    int last;
    int holdVal;
    fStart = 8'(fs);
    fStop  = 8'(fe);
    fStep  = 8'(st);
    dwell  = 16'(dw);
    loop   = lp;
    abort  = 1'b0;
    start  = 1'b1;
    n = sweepLen(fs, fe, st, dw);
    pushSweep(fs, fe, st, dw, abortAt, holdVal);
    stepCycle();
    last = (abortAt > 0) ? abortAt : n + 1;
    for (int c = 1; c <= last; c++) begin
      fStart = 8'($urandom);
      fStop  = 8'($urandom);
      fStep  = 8'($urandom);
      dwell  = 16'($urandom);
      start  = 1'($urandom_range(0, 1));
      abort  = (c == abortAt);
      stepCycle();
    end
    start = 1'b0;
    abort = 1'b0;
    loop  = 1'b0;
    checkOutput({name, "_idle"}, holdVal, 1'b0, 1'b0, (fe < fs));
    stepCycle();
    checkOutput({name, "_hold"}, holdVal, 1'b0, 1'b0, (fe < fs));
  endtask

  // Start held high through completion re-triggers a second identical sweep.
  task automatic retriggerTest();
    int holdVal;
    fStart = 8'd200; fStop = 8'd5; fStep = 8'd100; dwell = 16'd1;
    pushSweep(200, 5, 100, 1, 0, holdVal);
    pushSweep(200, 5, 100, 1, 0, holdVal);
    start = 1'b1;
    stepCycle();
    repeat (5) stepCycle();
    start = 1'b0;
    repeat (4) stepCycle();
    checkOutput("retrigger_idle", 5, 1'b0, 1'b0, 1'b1);
  endtask

  // Reset asserted in the 4th busy cycle of the ascending sweep.
  task automatic resetTest();
    int holdVal;
    fStart = 8'd10; fStop = 8'd20; fStep = 8'd4; dwell = 16'd3;
    pushSweep(10, 20, 4, 3, 3, holdVal);
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    repeat (3) stepCycle();
    #1 clrn = 1'b0;
    #1 checkOutput("reset_async", 1, 1'b0, 1'b0, 1'b0);
    repeat (2) stepCycle();
    checkOutput("reset_held", 1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 clrn = 1'b1;
    stepCycle();
    checkOutput("reset_release", 1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int fs;
    int fe;
    int st;
    int dw;
    int ab;
    int n;
    clrn = 1'b1;
    #1 clrn = 1'b0;
    #10 checkOutput("reset_state", 1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 clrn = 1'b1;
    stepCycle();
    checkOutput("post_reset_idle", 1, 1'b0, 1'b0, 1'b0);

    applyStimulus("asc",        10,  20,   4, 3, 0, 1'b0);
    applyStimulus("desc_clamp", 200,  5, 100, 1, 0, 1'b0);
    applyStimulus("degenerate", 3,    5,   0, 0, 0, 1'b0);
    applyStimulus("abort",      10,  20,   4, 3, 5, 1'b0);
    applyStimulus("restart",    10,  20,   4, 3, 0, 1'b0);
    applyStimulus("equal",      7,    7,   3, 2, 0, 1'b0);
    applyStimulus("abort_first", 50, 60,   1, 2, 1, 1'b0);
    retriggerTest();
    resetTest();
`ifdef DDS_SWEEP_LOOP_EN
    applyStimulus("loop",       10,  20,   4, 3, 30, 1'b1);
    applyStimulus("noloop_asc", 10,  20,   4, 3, 0, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      fs = $urandom_range(0, 255);
      fe = $urandom_range(0, 255);
      st = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60);
      dw = $urandom_range(0, 3);
      n  = sweepLen(fs, fe, st, dw);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
      applyStimulus("random", fs, fe, st, dw, ab, 1'b0);
    end

    repeat (3) stepCycle();
    compared++;
    if (sbq.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
